jt7759_rom_arb: RTL and testbench

JT7759_ROM_ARB -- requirements
Module: jt7759_rom_arb

---
 rtl/jt7759_rom_arb.sv | 151 +++++++++++++++
 tb/tb_jt7759_rom_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt7759_rom_arb.sv
// Two-requester read arbiter in front of a single ROM port. Each requester
// keeps a one-entry latch, so repeat reads of the same address hit without
// touching the ROM.
module jt7759_rom_arb #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 8
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          a_cs,
  input  logic [AW-1:0] a_addr,
  output logic [DW-1:0] a_data,
  output logic          a_ok,
  input  logic          b_cs,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_data,
  output logic          b_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic       GNT_A     = 1'b0;
  localparam logic       GNT_B     = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d;

  logic [AW-1:0] a_lat_addr_q, b_lat_addr_q;
  logic [DW-1:0] a_lat_data_q, b_lat_data_q;
  logic          a_lat_vld_q, b_lat_vld_q;
  logic          a_wr_d, b_wr_d;

  logic          a_pend, b_pend;
  logic          gnt_cs;
  logic [AW-1:0] gnt_addr;
  logic          abort;

  // Latch hit decode and request qualification
  assign a_ok     = a_cs & a_lat_vld_q & (a_lat_addr_q == a_addr);
  assign b_ok     = b_cs & b_lat_vld_q & (b_lat_addr_q == b_addr);
  assign a_data   = a_lat_data_q;
  assign b_data   = b_lat_data_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;

  assign a_pend   = a_cs & ~a_ok;
  assign b_pend   = b_cs & ~b_ok;
  assign gnt_cs   = (gnt_q == GNT_B) ? b_cs   : a_cs;
  assign gnt_addr = (gnt_q == GNT_B) ? b_addr : a_addr;
  // A requester that lets go or moves its address mid-access cancels it
  assign abort    = ~gnt_cs | (gnt_addr != cap_addr_q);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    cap_addr_d = cap_addr_q;
    a_wr_d     = 1'b0;
    b_wr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rom_cs_d = 1'b0;
        if (a_pend | b_pend) begin
          if (a_pend & b_pend) gnt_d = ~last_q;
          else                 gnt_d = b_pend ? GNT_B : GNT_A;
          last_d     = gnt_d;
          rom_addr_d = (gnt_d == GNT_B) ? b_addr : a_addr;
          cap_addr_d = rom_addr_d;
          rom_cs_d   = 1'b1;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          rom_cs_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          rom_cs_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (rom_ok) begin
          a_wr_d   = (gnt_q == GNT_A);
          b_wr_d   = (gnt_q == GNT_B);
          rom_cs_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_A;
      last_q     <= GNT_B;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      cap_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      cap_addr_q <= cap_addr_d;
    end
  end

  // Per-requester result latches, written only on a completed access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_lat_addr_q <= '0;
      a_lat_data_q <= '0;
      a_lat_vld_q  <= 1'b0;
      b_lat_addr_q <= '0;
      b_lat_data_q <= '0;
      b_lat_vld_q  <= 1'b0;
    end else begin
      if (a_wr_d) begin
        a_lat_addr_q <= cap_addr_q;
        a_lat_data_q <= rom_data;
        a_lat_vld_q  <= 1'b1;
      end
      if (b_wr_d) begin
        b_lat_addr_q <= cap_addr_q;
        b_lat_data_q <= rom_data;
        b_lat_vld_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jt7759_rom_arb.sv
// Directed bench for jt7759_rom_arb: a transaction-level model predicts every
// output each cycle, and literal checks pin the key scenarios.
module tb_jt7759_rom_arb;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_cs = 1'b0, b_cs = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data, b_data;
  logic          a_ok, b_ok;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_ok;

  logic          rom_fn = 1'b0;
  logic [DW-1:0] rom_fix = '0;
  logic          ok_auto = 1'b0;
  logic          ok_manual = 1'b0;
  int unsigned   ok_dly = 1;
  int unsigned   cs_cnt = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jt7759_rom_arb #(.AW(AW), .DW(DW)) dut (
    .rst(rst), .clk(clk),
    .a_cs(a_cs), .a_addr(a_addr), .a_data(a_data), .a_ok(a_ok),
    .b_cs(b_cs), .b_addr(b_addr), .b_data(b_data), .b_ok(b_ok),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  // ROM stand-in: data is either fixed or a function of the address
  assign rom_data = rom_fn ? (rom_addr[7:0] ^ 8'h3C) : rom_fix;
  always @(posedge clk) begin
    if (rst || !rom_cs) cs_cnt <= 0;
    else                cs_cnt <= cs_cnt + 1;
  end
  assign rom_ok = ok_auto ? (rom_cs && (cs_cnt >= ok_dly)) : ok_manual;

  // Transaction model: one access in flight, ROM answer accepted from its second cycle on
  logic          m_busy;
  int            m_age, m_who, m_last;
  logic [AW-1:0] m_req, m_rom_addr;
  logic          m_vld [2];
  logic [AW-1:0] m_la  [2];
  logic [DW-1:0] m_ld  [2];

  always @(posedge clk or posedge rst) begin : model
    logic          cs   [2];
    logic [AW-1:0] ad   [2];
    logic          pend [2];
    if (rst) begin
      m_busy = 1'b0; m_age = 0; m_who = 0; m_last = 1;
      m_req = '0; m_rom_addr = '0;
      for (int i = 0; i < 2; i++) begin
        m_vld[i] = 1'b0; m_la[i] = '0; m_ld[i] = '0;
      end
    end else begin
      cs[0] = a_cs; cs[1] = b_cs; ad[0] = a_addr; ad[1] = b_addr;
      for (int i = 0; i < 2; i++)
        pend[i] = cs[i] && !(m_vld[i] && (m_la[i] == ad[i]));
      if (!m_busy) begin
        if (pend[0] || pend[1]) begin
          m_who      = (pend[0] && pend[1]) ? (1 - m_last) : (pend[0] ? 0 : 1);
          m_last     = m_who;
          m_req      = ad[m_who];
          m_rom_addr = m_req;
          m_busy     = 1'b1;
          m_age      = 0;
        end
      end else if (!cs[m_who] || (ad[m_who] != m_req)) begin
        m_busy = 1'b0;
      end else if (m_age > 0 && rom_ok) begin
        m_vld[m_who] = 1'b1;
        m_la[m_who]  = m_req;
        m_ld[m_who]  = rom_data;
        m_busy       = 1'b0;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, exp);
    end
  endtask

  task automatic cmp_model();
    chk("m_rom_cs",   32'(rom_cs),   32'(m_busy));
    chk("m_rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    chk("m_a_data",   32'(a_data),   32'(m_ld[0]));
    chk("m_b_data",   32'(b_data),   32'(m_ld[1]));
    chk("m_a_ok",     32'(a_ok),     32'(a_cs && m_vld[0] && (m_la[0] == a_addr)));
    chk("m_b_ok",     32'(b_ok),     32'(b_cs && m_vld[1] && (m_la[1] == b_addr)));
  endtask

  task automatic sample();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  initial begin
    // reset
    sample();
    chk("rst_rom_cs", 32'(rom_cs), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_a_ok", 32'(a_ok), 0);
    chk("rst_b_ok", 32'(b_ok), 0);
    chk("rst_a_data", 32'(a_data), 0);
    adv();
    cyc(); cyc();
    rst = 1'b0;

    // contention: A wins the first tie, then both move and B wins
    ok_auto = 1'b1; ok_dly = 2; rom_fn = 1'b1;
    a_cs = 1'b1; a_addr = 17'h10; b_cs = 1'b1; b_addr = 17'h20;
    sample(); chk("ct_a_ok0", 32'(a_ok), 0); adv();
    sample(); chk("ct_cs_a", 32'(rom_cs), 1); chk("ct_addr_a", 32'(rom_addr), 32'h10); adv();
    cyc(); cyc();
    a_addr = 17'h11; b_addr = 17'h21;
    sample(); chk("ct_gap1", 32'(rom_cs), 0); chk("ct_a_data", 32'(a_data), 32'h2C); adv();
    sample(); chk("ct_rr_b_first", 32'(rom_addr), 32'h21); adv();
    cyc(); cyc();
    sample(); chk("ct_b_ok", 32'(b_ok), 1); chk("ct_b_data", 32'(b_data), 32'h1D);
    chk("ct_gap2", 32'(rom_cs), 0); adv();
    sample(); chk("ct_addr_a2", 32'(rom_addr), 32'h11); adv();
    cyc(); cyc();
    sample(); chk("ct_a_ok", 32'(a_ok), 1); chk("ct_a_data2", 32'(a_data), 32'h2D); adv();
    a_cs = 1'b0; b_cs = 1'b0; ok_auto = 1'b0;
    cyc();

    // single read with rom_ok tied high
    rom_fn = 1'b0; rom_fix = 8'h5A; ok_manual = 1'b1;
    a_cs = 1'b1; a_addr = 17'h00123;
    sample(); chk("sr_ok0", 32'(a_ok), 0); chk("sr_cs0", 32'(rom_cs), 0); adv();
    sample(); chk("sr_cs1", 32'(rom_cs), 1); chk("sr_addr", 32'(rom_addr), 32'h123); adv();
    sample(); chk("sr_cs2", 32'(rom_cs), 1); adv();
    sample(); chk("sr_ok", 32'(a_ok), 1); chk("sr_data", 32'(a_data), 32'h5A);
    chk("sr_cs3", 32'(rom_cs), 0); adv();
    sample(); chk("sr_hold_idle", 32'(rom_cs), 0); adv();

    // top address then zero is an ordinary miss
    a_addr = 17'h1FFFF;
    cyc(); cyc(); cyc();
    sample(); chk("wr_top_ok", 32'(a_ok), 1); adv();
    a_addr = 17'h0;
    sample(); chk("wr_zero_miss", 32'(a_ok), 0); adv();
    cyc(); cyc();
    sample(); chk("wr_zero_ok", 32'(a_ok), 1); adv();
    a_cs = 1'b0;
    cyc();

    // stale rom_ok during SETTLE is discarded
    ok_manual = 1'b0; rom_fix = 8'h11;
    b_cs = 1'b1; b_addr = 17'h55;
    cyc();
    ok_manual = 1'b1;
    cyc();
    ok_manual = 1'b0;
    repeat (4) begin
      sample(); chk("st_wait", 32'(b_ok), 0); adv();
    end
    ok_manual = 1'b1; rom_fix = 8'hC3;
    sample(); chk("st_wait_last", 32'(b_ok), 0); adv();
    ok_manual = 1'b0;
    sample(); chk("st_ok", 32'(b_ok), 1); chk("st_data", 32'(b_data), 32'hC3); adv();
    b_cs = 1'b0;
    cyc();

    // abort on address change wins over a simultaneous rom_ok
    rom_fn = 1'b1;
    a_cs = 1'b1; a_addr = 17'h40;
    cyc(); cyc();
    a_addr = 17'h41; ok_manual = 1'b1;
    sample(); chk("ab_ok0", 32'(a_ok), 0); adv();
    ok_manual = 1'b0;
    sample(); chk("ab_idle", 32'(rom_cs), 0); chk("ab_no_write", 32'(a_data), 32'h5A); adv();
    ok_manual = 1'b1;
    sample(); chk("ab_regrant", 32'(rom_addr), 32'h41); adv();
    cyc();
    sample(); chk("ab_ok", 32'(a_ok), 1); chk("ab_data", 32'(a_data), 32'h7D); adv();

    // latch hit after dropping cs, then reset mid-access on B
    a_addr = 17'h7;
    cyc(); cyc(); cyc();
    sample(); chk("ht_ok", 32'(a_ok), 1); chk("ht_data", 32'(a_data), 32'h3B); adv();
    a_cs = 1'b0;
    repeat (5) cyc();
    a_cs = 1'b1;
    sample(); chk("ht_hit", 32'(a_ok), 1); chk("ht_no_cs", 32'(rom_cs), 0); adv();
    sample(); chk("ht_no_cs2", 32'(rom_cs), 0); adv();
    b_cs = 1'b1; b_addr = 17'h99; ok_manual = 1'b0;
    cyc(); cyc();
    rst = 1'b1; ok_manual = 1'b1;
    sample(); chk("rs_cs", 32'(rom_cs), 0); chk("rs_a_ok", 32'(a_ok), 0);
    chk("rs_b_ok", 32'(b_ok), 0); chk("rs_a_data", 32'(a_data), 0);
    chk("rs_b_data", 32'(b_data), 0); adv();
    rst = 1'b0; b_cs = 1'b0;
    sample(); chk("rs_miss", 32'(a_ok), 0); chk("rs_cs0", 32'(rom_cs), 0); adv();
    sample(); chk("rs_cs1", 32'(rom_cs), 1); chk("rs_addr", 32'(rom_addr), 32'h7); adv();
    cyc();
    sample(); chk("rs_ok", 32'(a_ok), 1); chk("rs_data", 32'(a_data), 32'h3B); adv();
    a_cs = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
